// File: rtl/uart_tx_if.sv
// Byte handshake plus serial line and status toward the pad for the UART transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  // Byte producer side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  // Transmitter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per valid/ready handshake, sent as
// start / 8 data bits LSB first / optional even parity / 1 or 2 stop bits.
// All outputs come straight from flops; tx_done is a 1-cycle strobe.
module uart_tx_framer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Reject parameter values the framing logic cannot honour
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $fatal(1, "uart_tx_framer: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $fatal(1, "uart_tx_framer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_d;
  logic              ready_q, busy_q, done_q;
  logic              bit_end;

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

  assign bit_end = (baud_q == BAUD_LAST);

  // Next-state and next-line-value logic; each bit lasts CLKS_PER_BIT cycles
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (bus.tx_valid) begin
          state_d = START;
          shift_d = bus.tx_data;
          par_d   = ^bus.tx_data;
          bit_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if ((STOP_BITS == 2) && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any frame at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

endmodule
